// File: rtl/trigger_threshold_discriminator_pkg.sv
// Shared types and helpers for the trigger threshold discriminator.
package trig_disc_pkg;

    localparam int NSAMP_DEF = 8;
    localparam int NBITS_DEF = 5;
    localparam int POS_W     = $clog2(NSAMP_DEF);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        HOLDOFF = 2'd2
    } state_e;

    // Magnitude of a two's complement sample, one bit wider so -16 maps to 16.
    function automatic logic [NBITS_DEF:0] sample_mag(input logic [NBITS_DEF-1:0] s);
        logic [NBITS_DEF:0] ext;
        ext = {s[NBITS_DEF-1], s};
        return ext[NBITS_DEF] ? -ext : ext;
    endfunction

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [POS_W-1:0] lowest_set(input logic [NSAMP_DEF-1:0] m);
        logic [POS_W-1:0] pos;
        pos = '0;
        for (int i = NSAMP_DEF - 1; i >= 0; i--) begin
            if (m[i]) pos = POS_W'(i);
        end
        return pos;
    endfunction

endpackage

// File: rtl/trigger_threshold_discriminator_if.sv
// Sample/trigger bus between the filter chain, the discriminator and housekeeping.
interface trigger_threshold_discriminator_if
    import trig_disc_pkg::*;
#(
    parameter int NSAMP     = NSAMP_DEF,
    parameter int NBITS     = NBITS_DEF,
    parameter int HOLDOFF_W = 8,
    parameter int SCALER_W  = 16
);
    logic                       enable_i;
    logic [NBITS-1:0]           thresh_i;
    logic [HOLDOFF_W-1:0]       holdoff_i;
    logic [NSAMP*NBITS-1:0]     dat_i;
    logic [NSAMP-1:0]           hit_mask_o;
    logic                       trig_o;
    logic [$clog2(NSAMP)-1:0]   trig_pos_o;
    logic [SCALER_W-1:0]        scaler_o;
    logic                       scaler_valid_o;

    modport master (
        output enable_i, thresh_i, holdoff_i, dat_i,
        input  hit_mask_o, trig_o, trig_pos_o, scaler_o, scaler_valid_o
    );

    modport slave (
        input  enable_i, thresh_i, holdoff_i, dat_i,
        output hit_mask_o, trig_o, trig_pos_o, scaler_o, scaler_valid_o
    );
endinterface

// File: rtl/trigger_threshold_discriminator_disc.sv
// Per-sample magnitude compare; purely combinational.
module sample_discriminator
    import trig_disc_pkg::*;
(
    input  logic [NBITS_DEF-1:0] sample_i,
    input  logic [NBITS_DEF-1:0] thresh_i,
    output logic                 hit_o
);
    logic [NBITS_DEF:0] mag;

    // A zero threshold disables hits rather than matching everything.
    always_comb begin
        mag   = sample_mag(sample_i);
        hit_o = (thresh_i != '0) && (mag >= {1'b0, thresh_i});
    end
endmodule

// File: rtl/trigger_threshold_discriminator.sv
// Threshold trigger: registered hit mask, armed/holdoff FSM and gated rate scaler.
module trigger_threshold_discriminator
    import trig_disc_pkg::*;
#(
    parameter int NSAMP     = NSAMP_DEF,
    parameter int NBITS     = NBITS_DEF,
    parameter int HOLDOFF_W = 8,
    parameter int SCALER_W  = 16,
    parameter int GATE_LOG2 = 20
) (
    input  logic                                   aclk,
    input  logic                                   aresetn,
    trigger_threshold_discriminator_if.slave       bus
);
    localparam int PW = $clog2(NSAMP);

    logic [NSAMP-1:0]     hit_mask_d, hit_mask_q;
    state_e               state_d, state_q;
    logic [HOLDOFF_W-1:0] cnt_d, cnt_q;
    logic                 trig_d, trig_q;
    logic [PW-1:0]        trig_pos_d, trig_pos_q;
    logic [GATE_LOG2-1:0] gate_d, gate_q;
    logic [SCALER_W-1:0]  count_d, count_q, count_inc;
    logic [SCALER_W-1:0]  scaler_d, scaler_q;
    logic                 scaler_valid_d, scaler_valid_q;

    generate
        for (genvar gi = 0; gi < NSAMP; gi++) begin : g_disc
            sample_discriminator u_disc (
                .sample_i (bus.dat_i[gi*NBITS +: NBITS]),
                .thresh_i (bus.thresh_i),
                .hit_o    (hit_mask_d[gi])
            );
        end
    endgenerate

    // Trigger FSM: fire from the registered mask, then count down the holdoff.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        trig_d     = 1'b0;
        trig_pos_d = trig_pos_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.enable_i) state_d = ARMED;
            end
            ARMED: begin
                if (hit_mask_q != '0) begin
                    trig_d     = 1'b1;
                    trig_pos_d = lowest_set(hit_mask_q);
                    if (bus.holdoff_i != '0) begin
                        cnt_d   = bus.holdoff_i;
                        state_d = HOLDOFF;
                    end
                end
            end
            HOLDOFF: begin
                cnt_d = cnt_q - HOLDOFF_W'(1);
                if (cnt_q == HOLDOFF_W'(1)) state_d = ARMED;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // Disable only redirects the state; a trigger already decided still goes out.
        if (!bus.enable_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // Rate scaler: free-running gate, saturating trigger count latched at terminal count.
    always_comb begin
        gate_d    = gate_q + GATE_LOG2'(1);
        count_inc = (trig_q && (count_q != '1)) ? count_q + SCALER_W'(1) : count_q;
        if (gate_q == '1) begin
            scaler_d       = count_inc;
            count_d        = '0;
            scaler_valid_d = 1'b1;
        end else begin
            scaler_d       = scaler_q;
            count_d        = count_inc;
            scaler_valid_d = 1'b0;
        end
    end

    // State register for everything above.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            hit_mask_q     <= '0;
            state_q        <= IDLE;
            cnt_q          <= '0;
            trig_q         <= 1'b0;
            trig_pos_q     <= '0;
            gate_q         <= '0;
            count_q        <= '0;
            scaler_q       <= '0;
            scaler_valid_q <= 1'b0;
        end else begin
            hit_mask_q     <= hit_mask_d;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            trig_q         <= trig_d;
            trig_pos_q     <= trig_pos_d;
            gate_q         <= gate_d;
            count_q        <= count_d;
            scaler_q       <= scaler_d;
            scaler_valid_q <= scaler_valid_d;
        end
    end

    assign bus.hit_mask_o     = hit_mask_q;
    assign bus.trig_o         = trig_q;
    assign bus.trig_pos_o     = trig_pos_q;
    assign bus.scaler_o       = scaler_q;
    assign bus.scaler_valid_o = scaler_valid_q;

endmodule

// File: tb/tb_trigger_threshold_discriminator.sv
// Directed bench for the trigger threshold discriminator; two DUTs share stimulus,
// the second with a 2-bit scaler to exercise saturation.
module tb_trigger_threshold_discriminator;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    int   checks  = 0;
    int   passed  = 0;

    always #5 aclk = ~aclk;

    trigger_threshold_discriminator_if #(.SCALER_W(16)) bus_a ();
    trigger_threshold_discriminator_if #(.SCALER_W(2))  bus_b ();

    assign bus_b.enable_i  = bus_a.enable_i;
    assign bus_b.thresh_i  = bus_a.thresh_i;
    assign bus_b.holdoff_i = bus_a.holdoff_i;
    assign bus_b.dat_i     = bus_a.dat_i;

    trigger_threshold_discriminator #(.SCALER_W(16), .GATE_LOG2(4)) dut_a (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus_a.slave)
    );

    trigger_threshold_discriminator #(.SCALER_W(2), .GATE_LOG2(4)) dut_b (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus_b.slave)
    );

    localparam logic [39:0] FULL = {8{5'b10000}};

    function automatic logic [39:0] put(input int k, input logic [4:0] v);
        logic [39:0] d;
        d = '0;
        d[k*5 +: 5] = v;
        return d;
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        bus_a.enable_i  = 1'b0;
        bus_a.thresh_i  = 5'd0;
        bus_a.holdoff_i = 8'd0;
        bus_a.dat_i     = '0;
        aresetn         = 1'b0;
        tick();
        tick();
        checks++; if (bus_a.hit_mask_o !== 8'h00) $display("FAIL rst_mask: got %h want 00", bus_a.hit_mask_o); else passed++;
        checks++; if (bus_a.trig_o !== 1'b0) $display("FAIL rst_trig: got %b want 0", bus_a.trig_o); else passed++;
        checks++; if (bus_a.trig_pos_o !== 3'd0) $display("FAIL rst_pos: got %0d want 0", bus_a.trig_pos_o); else passed++;
        checks++; if (bus_a.scaler_o !== 16'd0) $display("FAIL rst_scaler: got %0d want 0", bus_a.scaler_o); else passed++;
        checks++; if (bus_a.scaler_valid_o !== 1'b0) $display("FAIL rst_valid: got %b want 0", bus_a.scaler_valid_o); else passed++;
        $display("reset: mask=%h trig=%b pos=%0d scaler=%0d", bus_a.hit_mask_o, bus_a.trig_o, bus_a.trig_pos_o, bus_a.scaler_o);
        aresetn = 1'b1;
    endtask

    task automatic test_threshold();
        logic [4:0] s3 [4];
        logic [7:0] em [4];
        logic       et [4];
        s3 = '{5'd5, 5'b11011, 5'd4, 5'd0};
        em = '{8'h08, 8'h08, 8'h00, 8'h00};
        et = '{1'b0, 1'b1, 1'b1, 1'b0};
        bus_a.thresh_i  = 5'd5;
        bus_a.holdoff_i = 8'd0;
        bus_a.enable_i  = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus_a.dat_i = put(3, s3[i]);
            tick();
            checks++; if (bus_a.hit_mask_o !== em[i]) $display("FAIL thr_mask step%0d: got %h want %h", i, bus_a.hit_mask_o, em[i]); else passed++;
            checks++; if (bus_a.trig_o !== et[i]) $display("FAIL thr_trig step%0d: got %b want %b", i, bus_a.trig_o, et[i]); else passed++;
            if (et[i]) begin
                checks++; if (bus_a.trig_pos_o !== 3'd3) $display("FAIL thr_pos step%0d: got %0d want 3", i, bus_a.trig_pos_o); else passed++;
            end
            $display("thr step%0d: mask=%h trig=%b pos=%0d", i, bus_a.hit_mask_o, bus_a.trig_o, bus_a.trig_pos_o);
        end
    endtask

    task automatic test_magnitude_position();
        logic [39:0] dv [4];
        logic [4:0]  th [4];
        logic [7:0]  em [4];
        logic        et [4];
        logic [2:0]  ep [4];
        dv = '{put(0, 5'b10000), put(0, 5'd15), put(2, 5'd7) | put(6, 5'b11000), 40'd0};
        th = '{5'd16, 5'd16, 5'd5, 5'd5};
        em = '{8'h01, 8'h00, 8'h44, 8'h00};
        et = '{1'b0, 1'b1, 1'b0, 1'b1};
        ep = '{3'd3, 3'd0, 3'd0, 3'd2};
        for (int i = 0; i < 4; i++) begin
            bus_a.dat_i    = dv[i];
            bus_a.thresh_i = th[i];
            tick();
            checks++; if (bus_a.hit_mask_o !== em[i]) $display("FAIL mag_mask step%0d: got %h want %h", i, bus_a.hit_mask_o, em[i]); else passed++;
            checks++; if (bus_a.trig_o !== et[i]) $display("FAIL mag_trig step%0d: got %b want %b", i, bus_a.trig_o, et[i]); else passed++;
            checks++; if (bus_a.trig_pos_o !== ep[i]) $display("FAIL mag_pos step%0d: got %0d want %0d", i, bus_a.trig_pos_o, ep[i]); else passed++;
            $display("mag step%0d: mask=%h trig=%b pos=%0d", i, bus_a.hit_mask_o, bus_a.trig_o, bus_a.trig_pos_o);
        end
    endtask

    task automatic test_holdoff();
        logic [17:0] et;
        // bit i = expected trig_o after step i
        et = 18'b01_1110_1010_1010_0010;
        bus_a.thresh_i = 5'd5;
        for (int i = 0; i < 18; i++) begin
            bus_a.dat_i     = (i < 16) ? put(0, 5'd5) : 40'd0;
            bus_a.holdoff_i = (i < 2) ? 8'd3 : ((i < 12) ? 8'd1 : 8'd0);
            tick();
            checks++; if (bus_a.trig_o !== et[i]) $display("FAIL hold_trig step%0d: got %b want %b", i, bus_a.trig_o, et[i]); else passed++;
            $display("hold step%0d: holdoff=%0d trig=%b", i, bus_a.holdoff_i, bus_a.trig_o);
        end
    endtask

    task automatic test_thresh_zero_enable();
        logic [4:0]  th [10];
        logic        en [10];
        logic [39:0] dv [10];
        logic [7:0]  em [10];
        logic        et [10];
        th = '{5'd0, 5'd0, 5'd5, 5'd5, 5'd5, 5'd5, 5'd5, 5'd5, 5'd5, 5'd5};
        en = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        dv = '{FULL, FULL, FULL, 40'd0, FULL, FULL, FULL, FULL, FULL, FULL};
        em = '{8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        et = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        bus_a.holdoff_i = 8'd0;
        for (int i = 0; i < 10; i++) begin
            bus_a.thresh_i = th[i];
            bus_a.enable_i = en[i];
            bus_a.dat_i    = dv[i];
            tick();
            checks++; if (bus_a.hit_mask_o !== em[i]) $display("FAIL en_mask step%0d: got %h want %h", i, bus_a.hit_mask_o, em[i]); else passed++;
            checks++; if (bus_a.trig_o !== et[i]) $display("FAIL en_trig step%0d: got %b want %b", i, bus_a.trig_o, et[i]); else passed++;
            if (i == 7) begin
                checks++; if (bus_a.trig_pos_o !== 3'd0) $display("FAIL en_pos: got %0d want 0", bus_a.trig_pos_o); else passed++;
            end
            $display("en step%0d: en=%b mask=%h trig=%b", i, bus_a.enable_i, bus_a.hit_mask_o, bus_a.trig_o);
        end
    endtask

    task automatic test_scaler();
        logic hit;
        aresetn = 1'b0;
        tick();
        aresetn         = 1'b1;
        bus_a.enable_i  = 1'b1;
        bus_a.thresh_i  = 5'd5;
        bus_a.holdoff_i = 8'd0;
        bus_a.dat_i     = '0;
        for (int p = 1; p <= 32; p++) begin
            hit = (p == 2) || (p == 4) || (p == 6) || (p == 8) || (p == 14) ||
                  (p >= 18 && p <= 28 && (p % 2 == 0));
            bus_a.dat_i = hit ? put(1, 5'd9) : 40'd0;
            tick();
            if (p == 15) begin
                checks++; if (bus_a.trig_o !== 1'b1) $display("FAIL sc_term_trig: got %b want 1", bus_a.trig_o); else passed++;
                checks++; if (bus_a.scaler_valid_o !== 1'b0) $display("FAIL sc_valid15: got %b want 0", bus_a.scaler_valid_o); else passed++;
            end
            if (p == 16) begin
                checks++; if (bus_a.scaler_valid_o !== 1'b1) $display("FAIL sc_valid16: got %b want 1", bus_a.scaler_valid_o); else passed++;
                checks++; if (bus_a.scaler_o !== 16'd5) $display("FAIL sc_count16: got %0d want 5", bus_a.scaler_o); else passed++;
                checks++; if (bus_b.scaler_o !== 2'd3) $display("FAIL sc_sat16: got %0d want 3", bus_b.scaler_o); else passed++;
            end
            if (p == 17) begin
                checks++; if (bus_a.scaler_valid_o !== 1'b0) $display("FAIL sc_valid17: got %b want 0", bus_a.scaler_valid_o); else passed++;
                checks++; if (bus_a.scaler_o !== 16'd5) $display("FAIL sc_hold17: got %0d want 5", bus_a.scaler_o); else passed++;
            end
            if (p == 32) begin
                checks++; if (bus_a.scaler_valid_o !== 1'b1) $display("FAIL sc_valid32: got %b want 1", bus_a.scaler_valid_o); else passed++;
                checks++; if (bus_a.scaler_o !== 16'd6) $display("FAIL sc_count32: got %0d want 6", bus_a.scaler_o); else passed++;
                checks++; if (bus_b.scaler_valid_o !== 1'b1) $display("FAIL sc_valid32_b: got %b want 1", bus_b.scaler_valid_o); else passed++;
                checks++; if (bus_b.scaler_o !== 2'd3) $display("FAIL sc_sat32: got %0d want 3", bus_b.scaler_o); else passed++;
            end
            $display("scaler cycle%0d: trig=%b valid=%b scaler_a=%0d scaler_b=%0d", p, bus_a.trig_o, bus_a.scaler_valid_o, bus_a.scaler_o, bus_b.scaler_o);
        end
    endtask

    task automatic test_async_reset();
        bus_a.holdoff_i = 8'd10;
        bus_a.dat_i     = put(5, 5'd6);
        tick();
        tick();
        checks++; if (bus_a.trig_o !== 1'b1) $display("FAIL ar_trig: got %b want 1", bus_a.trig_o); else passed++;
        tick();
        checks++; if (bus_a.trig_o !== 1'b0) $display("FAIL ar_holdoff: got %b want 0", bus_a.trig_o); else passed++;
        checks++; if (bus_a.hit_mask_o !== 8'h20) $display("FAIL ar_mask_pre: got %h want 20", bus_a.hit_mask_o); else passed++;
        checks++; if (bus_a.trig_pos_o !== 3'd5) $display("FAIL ar_pos_pre: got %0d want 5", bus_a.trig_pos_o); else passed++;
        checks++; if (bus_a.scaler_o !== 16'd6) $display("FAIL ar_scaler_pre: got %0d want 6", bus_a.scaler_o); else passed++;
        #3;
        aresetn = 1'b0;
        #1;
        checks++; if (bus_a.hit_mask_o !== 8'h00) $display("FAIL ar_mask: got %h want 00", bus_a.hit_mask_o); else passed++;
        checks++; if (bus_a.trig_pos_o !== 3'd0) $display("FAIL ar_pos: got %0d want 0", bus_a.trig_pos_o); else passed++;
        checks++; if (bus_a.scaler_o !== 16'd0) $display("FAIL ar_scaler: got %0d want 0", bus_a.scaler_o); else passed++;
        checks++; if (bus_b.scaler_o !== 2'd0) $display("FAIL ar_scaler_b: got %0d want 0", bus_b.scaler_o); else passed++;
        checks++; if (bus_a.trig_o !== 1'b0) $display("FAIL ar_trig0: got %b want 0", bus_a.trig_o); else passed++;
        $display("async reset: mask=%h pos=%0d scaler=%0d", bus_a.hit_mask_o, bus_a.trig_pos_o, bus_a.scaler_o);
        tick();
        aresetn = 1'b1;
        tick();
        checks++; if (bus_a.trig_o !== 1'b0) $display("FAIL ar_rel1_trig: got %b want 0", bus_a.trig_o); else passed++;
        checks++; if (bus_a.hit_mask_o !== 8'h20) $display("FAIL ar_rel1_mask: got %h want 20", bus_a.hit_mask_o); else passed++;
        tick();
        checks++; if (bus_a.trig_o !== 1'b1) $display("FAIL ar_rel2_trig: got %b want 1", bus_a.trig_o); else passed++;
        checks++; if (bus_a.trig_pos_o !== 3'd5) $display("FAIL ar_rel2_pos: got %0d want 5", bus_a.trig_pos_o); else passed++;
        $display("after release: trig=%b pos=%0d", bus_a.trig_o, bus_a.trig_pos_o);
    endtask

    initial begin
        test_reset();
        test_threshold();
        test_magnitude_position();
        test_holdoff();
        test_thresh_zero_enable();
        test_scaler();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
